// File: rtl/sonar_pkg.sv
// Shared types and default timing for the multi-channel sonar ranger.
// Defaults assume the 12 MHz HFOSC divide.
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLD
  } state_e;

  localparam int DEF_N_CH           = 4;
  localparam int DEF_TRIG_CYCLES    = 120;
  localparam int DEF_SLOT_CYCLES    = 720000;
  localparam int DEF_TIMEOUT_CYCLES = 360000;
  localparam int DEF_CYC_PER_CM     = 696;
  localparam int DEF_DIST_W         = 10;
  localparam int DEF_MAX_CM         = 500;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_echo_timer.sv
// Echo synchronizers, edge detect of the selected channel,
// centimetre prescaler and trigger-to-echo timeout counter.
module sonar_echo_timer
  import sonar_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int CH_W           = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYC_PER_CM     = DEF_CYC_PER_CM,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int MAX_CM         = DEF_MAX_CM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   echo,
  input  logic [CH_W-1:0]   sel,
  input  logic              run,
  input  logic              meas,
  output logic              rise,
  output logic              fall,
  output logic              tmo_hit,
  output logic [DIST_W-1:0] cm_nxt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(CYC_PER_CM) + 1;

  logic [N_CH-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  // s3 keeps a per-channel history so a channel switch never fakes an edge
  assign rise    = s2_q[sel] & ~s3_q[sel];
  assign fall    = ~s2_q[sel] & s3_q[sel];
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
  assign cm_nxt  = cm_d;

  always_comb begin
    s1_d    = echo;
    s2_d    = s1_q;
    s3_d    = s2_q;
    presc_d = '0;
    cm_d    = '0;
    tmo_d   = '0;
    if (meas) begin
      if (presc_q == PW'(CYC_PER_CM - 1)) begin
        presc_d = '0;
        cm_d    = (cm_q >= DIST_W'(MAX_CM)) ? DIST_W'(MAX_CM)
                                            : cm_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
        cm_d    = cm_q;
      end
    end
    if (run) begin
      tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      presc_q <= '0;
      cm_q    <= '0;
      tmo_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      presc_q <= presc_d;
      cm_q    <= cm_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: rtl/sonar_ranger_mc.sv
// Multi-channel HC-SR04 ranging engine: slot sequencer,
// round-robin channel pick and 1-deep valid/ready result register.
module sonar_ranger_mc
  import sonar_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int SLOT_CYCLES    = DEF_SLOT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYC_PER_CM     = DEF_CYC_PER_CM,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int MAX_CM         = DEF_MAX_CM,
  localparam int CH_W          = ch_bits(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trig,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [DIST_W-1:0] res_dist,
  output logic              res_timeout,
  output logic              res_drop
);

  localparam int SW = $clog2(SLOT_CYCLES) + 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, ptr_q, ptr_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [N_CH-1:0]   trig_q, trig_d;
  logic              res_valid_q, res_valid_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [DIST_W-1:0] res_dist_q, res_dist_d;
  logic              res_timeout_q, res_timeout_d;
  logic              res_drop_q, res_drop_d;
  logic              post, p_tmo;
  logic              rise, fall, tmo_hit;
  logic [DIST_W-1:0] cm_nxt;

  function automatic logic [CH_W-1:0] pick_ch(
    input logic [N_CH-1:0] en,
    input logic [CH_W-1:0] ptr
  );
    logic [CH_W-1:0] r;
    logic            got;
    int              j;
    r   = '0;
    got = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!got && en[j[CH_W-1:0]]) begin
        got = 1'b1;
        r   = j[CH_W-1:0];
      end
    end
    return r;
  endfunction

  sonar_echo_timer #(
    .N_CH          (N_CH),
    .CH_W          (CH_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CYC_PER_CM    (CYC_PER_CM),
    .DIST_W        (DIST_W),
    .MAX_CM        (MAX_CM)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .echo   (echo),
    .sel    (ch_q),
    .run    (state_q == S_WAIT_RISE || state_q == S_MEASURE),
    .meas   (state_q == S_MEASURE),
    .rise   (rise),
    .fall   (fall),
    .tmo_hit(tmo_hit),
    .cm_nxt (cm_nxt)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    slot_d  = (slot_q == SW'(SLOT_CYCLES - 1)) ? slot_q
                                               : slot_q + 1'b1;
    post    = 1'b0;
    p_tmo   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // the IDLE cycle is slot cycle 0, so slots stay exactly SLOT_CYCLES
        if (|ch_en) begin
          ch_d    = pick_ch(ch_en, ptr_q);
          slot_d  = SW'(1);
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (slot_q >= SW'(TRIG_CYCLES)) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (tmo_hit) begin
          post    = 1'b1;
          p_tmo   = 1'b1;
          state_d = S_HOLD;
        end else if (rise) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          post    = 1'b1;
          state_d = S_HOLD;
        end else if (tmo_hit) begin
          post    = 1'b1;
          p_tmo   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (slot_q >= SW'(SLOT_CYCLES - 1)) begin
          ptr_d   = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    trig_d = '0;
    if (state_q == S_TRIG) trig_d[ch_q] = 1'b1;

    res_valid_d   = res_valid_q & ~res_ready;
    res_ch_d      = res_ch_q;
    res_dist_d    = res_dist_q;
    res_timeout_d = res_timeout_q;
    res_drop_d    = 1'b0;
    if (post) begin
      if (!res_valid_q || res_ready) begin
        res_valid_d   = 1'b1;
        res_ch_d      = ch_q;
        res_dist_d    = p_tmo ? '0 : cm_nxt;
        res_timeout_d = p_tmo;
      end else begin
        res_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      ptr_q         <= '0;
      slot_q        <= '0;
      trig_q        <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_dist_q    <= '0;
      res_timeout_q <= 1'b0;
      res_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      ptr_q         <= ptr_d;
      slot_q        <= slot_d;
      trig_q        <= trig_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_dist_q    <= res_dist_d;
      res_timeout_q <= res_timeout_d;
      res_drop_q    <= res_drop_d;
    end
  end

  assign trig        = trig_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_dist    = res_dist_q;
  assign res_timeout = res_timeout_q;
  assign res_drop    = res_drop_q;

endmodule

// File: tb/tb_sonar_ranger_mc.sv
// Directed bench for sonar_ranger_mc with small timing parameters:
// vector table of slots plus hand-written backpressure and reset cases.
module tb_sonar_ranger_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_en, echo, trig;
  logic       res_valid, res_ready;
  logic [1:0] res_ch;
  logic [9:0] res_dist;
  logic       res_timeout, res_drop;

  always #5 clk = ~clk;

  sonar_ranger_mc #(
    .N_CH          (4),
    .TRIG_CYCLES   (4),
    .SLOT_CYCLES   (200),
    .TIMEOUT_CYCLES(100),
    .CYC_PER_CM    (10),
    .DIST_W        (10),
    .MAX_CM        (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .echo       (echo),
    .trig       (trig),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ch     (res_ch),
    .res_dist   (res_dist),
    .res_timeout(res_timeout),
    .res_drop   (res_drop)
  );

  typedef struct {
    int ch;
    int dly;
    int hi;
    int rdy;
    int exp_dist;
    int exp_tmo;
  } vec_t;

  vec_t vecs[6];

  int n_chk = 0, n_fail = 0, cyc = 0, drop_cnt = 0;
  int cap_cyc = -1, cap_ch, cap_dist, cap_tmo;
  int rise_cyc = -1, rise_ch = -1, fall_cyc = -1, prev_rise = -1;
  int t0;
  logic [3:0] trig_prev = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act,
                           input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (res_drop) drop_cnt++;
    if (res_valid && cap_cyc < 0) begin
      cap_cyc  = cyc;
      cap_ch   = int'(res_ch);
      cap_dist = int'(res_dist);
      cap_tmo  = int'(res_timeout);
    end
    if (trig != 0 && trig_prev == 0) begin
      rise_cyc = cyc;
      rise_ch  = -1;
      for (int i = 0; i < 4; i++) if (trig[i]) rise_ch = i;
      if ($countones(trig) != 1) begin
        n_chk++;
        n_fail++;
        $display("FAIL trig_onehot: got %b", trig);
      end
    end
    if (trig == 0 && trig_prev != 0) fall_cyc = cyc;
    trig_prev = trig;
  endtask

  task automatic wait_rise(input int budget, input string nm);
    rise_cyc = -1;
    for (int i = 0; i < budget && rise_cyc < 0; i++) tick();
    check({nm, "_trig_seen"}, int'(rise_cyc >= 0), 1);
  endtask

  task automatic wait_fall(input string nm);
    fall_cyc = -1;
    for (int i = 0; i < 20 && fall_cyc < 0; i++) tick();
    check({nm, "_trig_fall"}, int'(fall_cyc >= 0), 1);
  endtask

  task automatic wait_cap(input string nm);
    for (int i = 0; i < 150 && cap_cyc < 0; i++) tick();
    check({nm, "_valid_seen"}, int'(cap_cyc >= 0), 1);
  endtask

  task automatic drive_echo(input int ch, input int dly, input int hi);
    repeat (dly) tick();
    if (hi > 0) begin
      echo[ch] = 1'b1;
      repeat (hi) tick();
      echo[ch] = 1'b0;
    end
  endtask

  task automatic handshake(input string nm);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({nm, "_valid_low"}, int'(res_valid), 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    string nm;
    nm        = $sformatf("v%0d", k);
    cap_cyc   = -1;
    res_ready = v.rdy[0];
    wait_rise(400, nm);
    check({nm, "_trig_ch"}, rise_ch, v.ch);
    if (prev_rise >= 0) check({nm, "_slot"}, rise_cyc - prev_rise, 200);
    prev_rise = rise_cyc;
    wait_fall(nm);
    drive_echo(v.ch, v.dly, v.hi);
    wait_cap(nm);
    check({nm, "_ch"}, cap_ch, v.ch);
    check({nm, "_dist"}, cap_dist, v.exp_dist);
    check({nm, "_tmo"}, cap_tmo, v.exp_tmo);
    if (v.exp_tmo != 0)
      check_rng({nm, "_tmo_lat"}, cap_cyc - fall_cyc, 100, 101);
    handshake(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ch: 0, dly: 5, hi: 35,  rdy: 1, exp_dist: 3, exp_tmo: 0};
    vecs[1] = '{ch: 2, dly: 5, hi: 85,  rdy: 0, exp_dist: 6, exp_tmo: 0};
    vecs[2] = '{ch: 0, dly: 5, hi: 110, rdy: 0, exp_dist: 0, exp_tmo: 1};
    vecs[3] = '{ch: 2, dly: 5, hi: 0,   rdy: 0, exp_dist: 0, exp_tmo: 1};
    vecs[4] = '{ch: 0, dly: 3, hi: 9,   rdy: 0, exp_dist: 0, exp_tmo: 0};
    vecs[5] = '{ch: 2, dly: 3, hi: 20,  rdy: 1, exp_dist: 2, exp_tmo: 0};

    rst       = 1'b1;
    ch_en     = 4'b0000;
    echo      = 4'b0000;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_trig", int'(trig), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_ch", int'(res_ch), 0);
    check("rst_dist", int'(res_dist), 0);
    check("rst_tmo", int'(res_timeout), 0);
    check("rst_drop", int'(res_drop), 0);

    rst      = 1'b0;
    rise_cyc = -1;
    repeat (50) tick();
    check("en0_no_trig", int'(rise_cyc >= 0), 0);

    ch_en = 4'b1000;
    t0    = cyc;
    wait_rise(10, "en8");
    check("en8_trig_ch", rise_ch, 3);
    check_rng("en8_trig_delay", rise_cyc - t0, 1, 2);
    prev_rise = rise_cyc;
    ch_en     = 4'b0101;
    cap_cyc   = -1;
    wait_fall("ch3");
    wait_cap("ch3");
    check("ch3_ch", cap_ch, 3);
    check("ch3_dist", cap_dist, 0);
    check("ch3_tmo", cap_tmo, 1);
    check_rng("ch3_tmo_lat", cap_cyc - fall_cyc, 100, 101);
    handshake("ch3");

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // two results while the consumer stalls: second is dropped
    res_ready = 1'b0;
    cap_cyc   = -1;
    wait_rise(400, "bp0");
    check("bp0_trig_ch", rise_ch, 0);
    check("bp0_slot", rise_cyc - prev_rise, 200);
    prev_rise = rise_cyc;
    wait_fall("bp0");
    drive_echo(0, 5, 35);
    wait_cap("bp0");
    check("bp0_dist", cap_dist, 3);
    drop_cnt = 0;
    wait_rise(400, "bp1");
    check("bp1_trig_ch", rise_ch, 2);
    check("bp1_slot", rise_cyc - prev_rise, 200);
    wait_fall("bp1");
    drive_echo(2, 5, 85);
    repeat (10) tick();
    check("bp_drop_pulses", drop_cnt, 1);
    check("bp_valid_held", int'(res_valid), 1);
    check("bp_ch_held", int'(res_ch), 0);
    check("bp_dist_held", int'(res_dist), 3);
    check("bp_tmo_held", int'(res_timeout), 0);

    // reset in the middle of a measurement
    wait_rise(400, "rm");
    check("rm_trig_ch", rise_ch, 0);
    wait_fall("rm");
    echo[0] = 1'b1;
    repeat (25) tick();
    check("rm_valid_pre", int'(res_valid), 1);
    rst = 1'b1;
    #1;
    check("rm_trig_async", int'(trig), 0);
    check("rm_valid_async", int'(res_valid), 0);
    check("rm_dist_async", int'(res_dist), 0);
    echo = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    t0  = cyc;
    wait_rise(10, "rr");
    check("rr_trig_ch", rise_ch, 0);
    check("rr_trig_delay", rise_cyc - t0, 2);
    check("rr_no_valid", int'(res_valid), 0);

    // reset while the trigger pulse is high drops it at once
    check("rt_trig_pre", int'(trig), 1);
    rst = 1'b1;
    #1;
    check("rt_trig_async", int'(trig), 0);
    repeat (2) tick();
    rst = 1'b0;
    t0  = cyc;
    wait_rise(10, "rt");
    check("rt_trig_ch", rise_ch, 0);
    check("rt_trig_delay", rise_cyc - t0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
